pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic datapath. It splits a WIDTH-bit operand pair into STAGES equal segments. Each segment is built from 4-bit lookahead groups with a two-level group propagate/generate tree. Carry, partial sum and group P/G are registered between segments, so throughput is one operation per cycle and latency is STAGES cycles. A valid/ready handshake on both sides supports backpressure from downstream.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4*STAGES
- STAGES, 4, number of pipeline segments (1..WIDTH/4); SEG = WIDTH/STAGES bits per segment
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (ignored when sub=1)
- sub  input  1  0: a+b+c_in; 1: a-b (a + ~b + 1)
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference, modulo 2^WIDTH
- c_out  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow
- pg  output  1  full-width group propagate (AND of all p_i)
- gg  output  1  full-width group generate, independent of carry-in

## Operation
- Operand conditioning at accept: b_eff = sub ? ~b : b; cin_eff = sub ? 1 : c_in. Per bit p_i = a_i ^ b_eff_i, g_i = a_i & b_eff_i.
- Segment k (k = 0..STAGES-1) is computed in pipeline stage k:
  - Inputs: bits [k*SEG +: SEG] and carry register C_{k-1} (stage 0 uses cin_eff).
  - Internal: 4-bit groups; group pg/gg per group; lookahead carries across groups within the segment. No ripple across more than one group boundary.
  - Produces s bits, carry C_k, and running group terms: PG_k = PG_{k-1} & pg_seg, GG_k = gg_seg | (pg_seg & GG_{k-1}). PG_{-1}=1, GG_{-1}=0.
- Unprocessed upper operand bits (p, g only) and finished lower sum bits travel with the beat in stage registers.
- Final stage registers drive the outputs:
  - s; c_out = C_{STAGES-1}
  - ovf = carry into MSB ^ c_out
  - pg = PG_{STAGES-1}; gg = GG_{STAGES-1}
- Each stage holds a valid bit. A global enable advances every stage together: adv = !out_valid | out_ready. in_ready = adv. A beat is accepted when in_valid & in_ready. Bubbles propagate as invalid slots and are not collapsed.
- Output beat is transferred when out_valid & out_ready. While out_valid & !out_ready, s/c_out/ovf/pg/gg and all stage registers hold stable.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits 0; out_valid=0; s=0, c_out=0, ovf=0, pg=0, gg=0. in_ready=1 after reset (follows adv). Stage data registers clear to 0.
- Latency: a beat accepted at rising edge t presents out_valid=1 with its result after edge t+STAGES−1. It is visible in the cycle following edge t+STAGES−1, given no stall. STAGES=1 therefore gives a registered single-cycle result.
- Throughput: one beat per cycle with out_ready held high.
- Stall: each cycle with out_valid=1 and out_ready=0 adds one cycle to every in-flight beat. in_ready is 0 in those cycles.
- Simultaneous output transfer and input accept in the same cycle is legal, with no lost or duplicated beats.
- Reset asserted mid-stream discards all in-flight beats. No result of a pre-reset beat ever appears after reset deasserts.
- Critical path: one segment of SEG bits through a two-level lookahead plus one register. No combinational path from a/b/c_in/sub to any output. in_ready depends combinationally only on out_valid and out_ready.

## Test plan
- Reset: hold rst_n=0 with random inputs and in_valid=1 -> out_valid=0, s=0, c_out=0, ovf=0, pg=0, gg=0. After release, in_ready=1.
- Carry chain (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, c_in=0, sub=0 -> after 4 cycles s=0x0000, c_out=1, ovf=0, pg=0, gg=1. Then a=0x5555, b=0xAAAA, c_in=1 -> s=0x0000, c_out=1, pg=1, gg=0.
- Subtract/overflow: 0x0005−0x0007 -> s=0xFFFE, c_out=0, ovf=0. 0x7FFF+0x0001 -> s=0x8000, c_out=0, ovf=1. 0x8000−0x0001 -> s=0x7FFF, c_out=1, ovf=1.
- Backpressure stream: 200 random beats, in_valid and out_ready each random 50% -> results match the reference model in order. No drops or duplicates. Outputs stable during stalls.
- Reset mid-operation: accept 3 beats, assert rst_n low for 1 cycle before any output -> no out_valid until a new beat is accepted post-reset.
- Parameter sweep: (WIDTH=8, STAGES=1) latency 1; (WIDTH=32, STAGES=2) latency 2; (WIDTH=64, STAGES=4) latency 4. Each runs 1000 random add/sub beats against the model.

Source files
------------

// File: rtl/pipelined_cla_adder_if.sv
// Handshake bundle for the pipelined carry-lookahead adder/subtractor:
// operand beat in (valid/ready), result beat out (valid/ready).
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             pg;
    logic             gg;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, pg, gg
    );

    // The adder itself
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, s, c_out, ovf, pg, gg
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. The operand is cut into STAGES
// segments of SEG bits; segment k is resolved in pipeline stage k with a
// two-level (4-bit group, then segment) lookahead. Each stage forwards only
// the operand p/g bits still to be processed and the sum bits already done.
// All stages advance together under one enable, so bubbles are preserved.
module pipelined_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NG   = SEG / 4;
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic [SEG-1:0] sum;
        logic           cout;
        logic           pg;
        logic           gg;
    } seg_res_t;

    // One segment: group P/G per 4 bits, then every group carry and every
    // bit carry written as a flat sum of products of the level below, so no
    // carry ripples through more than one group boundary.
    function automatic seg_res_t seg_add(input logic [SEG-1:0] p,
                                         input logic [SEG-1:0] g,
                                         input logic           cin);
        logic [NG-1:0]  gp;
        logic [NG-1:0]  gq;
        logic [NG:0]    gc;
        logic [SEG-1:0] c;
        logic           t;
        seg_res_t       r;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[4*j +: 4];
            gq[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        for (int j = 0; j <= NG; j++) begin
            t = cin;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gq[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            for (int bi = 0; bi < 4; bi++) begin
                t = gc[j];
                for (int m = 0; m < bi; m++) t = t & p[4*j+m];
                c[4*j+bi] = t;
                for (int i = 0; i < bi; i++) begin
                    t = g[4*j+i];
                    for (int m = i + 1; m < bi; m++) t = t & p[4*j+m];
                    c[4*j+bi] = c[4*j+bi] | t;
                end
            end
        end
        r.sum  = p ^ c;
        r.cout = gc[NG];
        r.pg   = &gp;
        r.gg   = 1'b0;
        for (int i = 0; i < NG; i++) begin
            t = gq[i];
            for (int m = i + 1; m < NG; m++) t = t & gp[m];
            r.gg = r.gg | t;
        end
        return r;
    endfunction

    logic adv;

    // Single global enable: everything moves unless a result is stuck.
    assign adv          = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // operand bits still pending after this stage
        localparam int REM = WIDTH - (k + 1) * SEG;

        logic [WIDTH-k*SEG-1:0] p_src;
        logic [WIDTH-k*SEG-1:0] g_src;
        logic                   c_src;
        logic                   pga_src;
        logic                   gga_src;
        logic                   vld_src;
        logic [(k+1)*SEG-1:0]   sum_nxt;
        seg_res_t               seg;

        logic                   vld_r;
        logic [(k+1)*SEG-1:0]   sum_r;
        logic                   c_r;
        logic                   pga_r;
        logic                   gga_r;

        if (k == 0) begin : g_head
            // ---- operand conditioning feeds stage 0 ----
            assign p_src   = bus.a ^ (bus.b ^ {WIDTH{bus.sub}});
            assign g_src   = bus.a & (bus.b ^ {WIDTH{bus.sub}});
            assign c_src   = bus.sub | bus.c_in;
            assign pga_src = 1'b1;
            assign gga_src = 1'b0;
            assign vld_src = bus.in_valid;
            assign sum_nxt = seg.sum;
        end else begin : g_link
            // ---- stage k-1 registers feed stage k ----
            assign p_src   = g_st[k-1].g_fwd.p_r;
            assign g_src   = g_st[k-1].g_fwd.g_r;
            assign c_src   = g_st[k-1].c_r;
            assign pga_src = g_st[k-1].pga_r;
            assign gga_src = g_st[k-1].gga_r;
            assign vld_src = g_st[k-1].vld_r;
            assign sum_nxt = {seg.sum, g_st[k-1].sum_r};
        end

        assign seg = seg_add(p_src[SEG-1:0], g_src[SEG-1:0], c_src);

        // Stage register: valid, finished sum bits, segment carry, running P/G
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                sum_r <= '0;
                c_r   <= 1'b0;
                pga_r <= 1'b0;
                gga_r <= 1'b0;
            end else if (adv) begin
                vld_r <= vld_src;
                sum_r <= sum_nxt;
                c_r   <= seg.cout;
                pga_r <= pga_src & seg.pg;
                gga_r <= seg.gg | (seg.pg & gga_src);
            end
        end

        if (REM > 0) begin : g_fwd
            logic [REM-1:0] p_r;
            logic [REM-1:0] g_r;

            // Carry the unprocessed upper p/g bits along with the beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_r <= '0;
                    g_r <= '0;
                end else if (adv) begin
                    p_r <= p_src[WIDTH-k*SEG-1:SEG];
                    g_r <= g_src[WIDTH-k*SEG-1:SEG];
                end
            end
        end else begin : g_tail
            logic ovf_r;

            // Carry into MSB is recovered as p_msb ^ s_msb; overflow = that ^ carry out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (adv) begin
                    ovf_r <= p_src[SEG-1] ^ seg.sum[SEG-1] ^ seg.cout;
                end
            end
        end
    end

    // ---- final stage registers drive the result port ----
    assign bus.out_valid = g_st[LAST].vld_r;
    assign bus.s         = g_st[LAST].sum_r;
    assign bus.c_out     = g_st[LAST].c_r;
    assign bus.ovf       = g_st[LAST].g_tail.ovf_r;
    assign bus.pg        = g_st[LAST].pga_r;
    assign bus.gg        = g_st[LAST].gga_r;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: main 16-bit/4-stage instance plus three
// parameter-sweep instances driven from a shared stimulus.
module tb_pipelined_cla_adder;
    localparam int W  = 16;
    localparam int ST = 4;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        pg;
        logic        gg;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_cla_adder_if #(.WIDTH(W)) m_if ();
    pipelined_cla_adder #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));

    logic        sw_valid = 1'b0;
    logic        sw_cin   = 1'b0;
    logic        sw_sub   = 1'b0;
    logic [63:0] sw_a     = '0;
    logic [63:0] sw_b     = '0;

    pipelined_cla_adder_if #(.WIDTH(8))  w8_if ();
    pipelined_cla_adder_if #(.WIDTH(32)) w32_if ();
    pipelined_cla_adder_if #(.WIDTH(64)) w64_if ();
    pipelined_cla_adder #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(w8_if.slave));
    pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) dut32 (.clk(clk), .rst_n(rst_n), .bus(w32_if.slave));
    pipelined_cla_adder #(.WIDTH(64), .STAGES(4)) dut64 (.clk(clk), .rst_n(rst_n), .bus(w64_if.slave));

    assign w8_if.in_valid  = sw_valid;
    assign w8_if.a         = sw_a[7:0];
    assign w8_if.b         = sw_b[7:0];
    assign w8_if.c_in      = sw_cin;
    assign w8_if.sub       = sw_sub;
    assign w8_if.out_ready = 1'b1;
    assign w32_if.in_valid  = sw_valid;
    assign w32_if.a         = sw_a[31:0];
    assign w32_if.b         = sw_b[31:0];
    assign w32_if.c_in      = sw_cin;
    assign w32_if.sub       = sw_sub;
    assign w32_if.out_ready = 1'b1;
    assign w64_if.in_valid  = sw_valid;
    assign w64_if.a         = sw_a;
    assign w64_if.b         = sw_b;
    assign w64_if.c_in      = sw_cin;
    assign w64_if.sub       = sw_sub;
    assign w64_if.out_ready = 1'b1;

    res_t expq[$];
    int   accq[$];

    // Reference: plain wide integer arithmetic on the conditioned operands
    function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
        logic [64:0] mask, av, bv, full, nc;
        logic        ce;
        res_t        r;
        mask = (65'd1 << w) - 65'd1;
        av   = {1'b0, a} & mask;
        bv   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        ce   = sub ? 1'b1 : cin;
        full = av + bv + {64'd0, ce};
        nc   = av + bv;
        r.s  = full[63:0] & mask[63:0];
        r.c  = full[w];
        r.o  = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
        r.pg = ((av ^ bv) == mask);
        r.gg = nc[w];
        return r;
    endfunction

    function automatic res_t main_out();
        res_t r;
        r = '{s: 64'(m_if.s), c: m_if.c_out, o: m_if.ovf, pg: m_if.pg, gg: m_if.gg};
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m_if.in_valid  = 1'b1;
            m_if.a         = W'($urandom);
            m_if.b         = W'($urandom);
            m_if.c_in      = 1'($urandom_range(0, 1));
            m_if.sub       = 1'($urandom_range(0, 1));
            m_if.out_ready = 1'($urandom_range(0, 1));
        end
        #1;
        checks++; if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", m_if.out_valid); end
        checks++; if (m_if.s !== '0) begin errors++; $display("FAIL reset_s: got %h expected 0000", m_if.s); end
        checks++; if (m_if.c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out: got %b expected 0", m_if.c_out); end
        checks++; if (m_if.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", m_if.ovf); end
        checks++; if (m_if.pg !== 1'b0) begin errors++; $display("FAIL reset_pg: got %b expected 0", m_if.pg); end
        checks++; if (m_if.gg !== 1'b0) begin errors++; $display("FAIL reset_gg: got %b expected 0", m_if.gg); end
        @(negedge clk);
        rst_n          = 1'b1;
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        #1;
        checks++; if (m_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", m_if.in_ready); end
    endtask

    // Carry chain, subtract and overflow corner cases, sent back to back
    task automatic test_carry_sub();
        logic [15:0] ta [6] = '{16'hFFFF, 16'h5555, 16'h0005, 16'h0005, 16'h7FFF, 16'h8000};
        logic [15:0] tb [6] = '{16'h0001, 16'hAAAA, 16'h0007, 16'h0007, 16'h0001, 16'h0001};
        logic        tc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [19:0] tx [6] = '{20'h00009, 20'h0000A, 20'hFFFE0, 20'hFFFE0, 20'h80004, 20'h7FFFD};
        logic [19:0] tv;
        res_t        e, act;
        int          idx = 0, got = 0, lat;
        expq.delete(); accq.delete();
        for (int t = 0; t < 60 && got < 6; t++) begin
            @(negedge clk);
            m_if.out_ready = 1'b1;
            if (idx < 6) begin
                m_if.in_valid = 1'b1;
                m_if.a = ta[idx]; m_if.b = tb[idx]; m_if.c_in = tc[idx]; m_if.sub = ts[idx];
            end else begin
                m_if.in_valid = 1'b0;
            end
            #1;
            if (m_if.out_valid) begin
                checks++;
                act = main_out();
                if (expq.size() == 0) begin
                    errors++; $display("FAIL directed_spurious: got %h expected no beat", act);
                end else begin
                    e = expq.pop_front();
                    lat = cyc - accq.pop_front();
                    if (act !== e) begin errors++; $display("FAIL directed_result: got %h expected %h", act, e); end
                    checks++;
                    if (lat != ST) begin errors++; $display("FAIL directed_latency: got %0d expected %0d", lat, ST); end
                end
                got++;
            end
            if (m_if.in_valid && m_if.in_ready) begin
                tv = tx[idx];
                e = '{s: 64'(tv[19:4]), c: tv[3], o: tv[2], pg: tv[1], gg: tv[0]};
                expq.push_back(e); accq.push_back(cyc); idx++;
            end
        end
        checks++; if (got != 6) begin errors++; $display("FAIL directed_count: got %0d expected 6", got); end
    endtask

    // Random in_valid/out_ready, ordering, stall hold and in_ready equation
    task automatic test_backpressure();
        res_t act, e, held;
        int   sent = 0, got = 0;
        logic stall = 1'b0;
        expq.delete();
        held = '0;
        for (int t = 0; t < 3000 && (sent < 200 || got < 200); t++) begin
            @(negedge clk);
            m_if.in_valid  = (sent < 200) && ($urandom_range(0, 1) == 1);
            m_if.a         = W'($urandom);
            m_if.b         = W'($urandom);
            m_if.c_in      = 1'($urandom_range(0, 1));
            m_if.sub       = 1'($urandom_range(0, 1));
            m_if.out_ready = 1'($urandom_range(0, 1));
            #1;
            act = main_out();
            if (stall) begin
                checks++;
                if (m_if.out_valid !== 1'b1 || act !== held) begin
                    errors++; $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_if.out_valid, act, held);
                end
            end
            checks++;
            if (m_if.in_ready !== (!m_if.out_valid || m_if.out_ready)) begin
                errors++; $display("FAIL bp_in_ready: got %b expected %b", m_if.in_ready, (!m_if.out_valid || m_if.out_ready));
            end
            if (m_if.out_valid && m_if.out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL bp_spurious: got %h expected no beat", act);
                end else begin
                    e = expq.pop_front();
                    if (act !== e) begin errors++; $display("FAIL bp_result: got %h expected %h", act, e); end
                end
                got++;
            end
            stall = m_if.out_valid && !m_if.out_ready;
            held  = act;
            if (m_if.in_valid && m_if.in_ready) begin
                expq.push_back(model(W, 64'(m_if.a), 64'(m_if.b), m_if.c_in, m_if.sub));
                sent++;
            end
        end
        checks++;
        if (got != 200 || expq.size() != 0) begin
            errors++; $display("FAIL bp_count: got %0d left %0d expected 200 left 0", got, expq.size());
        end
        m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk); #1;
            checks++;
            if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate: got out_valid=%b expected 0", m_if.out_valid); end
        end
    endtask

    // Reset while three beats are in flight; nothing from them may emerge
    task automatic test_reset_midstream();
        res_t e, act;
        int   acc, lat;
        logic seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
            m_if.a = W'($urandom); m_if.b = W'($urandom); m_if.c_in = 1'b0; m_if.sub = 1'b0;
        end
        @(negedge clk);
        m_if.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk); #1;
            checks++;
            if (m_if.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_ghost: got out_valid=%b expected 0", m_if.out_valid); end
        end
        @(negedge clk);
        m_if.in_valid = 1'b1; m_if.a = 16'h1234; m_if.b = 16'h4321; m_if.c_in = 1'b1; m_if.sub = 1'b1;
        #1;
        e = model(W, 64'h1234, 64'h4321, 1'b1, 1'b1);
        acc = cyc;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            m_if.in_valid = 1'b0;
            #1;
            if (m_if.out_valid) begin
                seen = 1'b1;
                act = main_out();
                lat = cyc - acc;
                checks++; if (act !== e) begin errors++; $display("FAIL midreset_result: got %h expected %h", act, e); end
                checks++; if (lat != ST) begin errors++; $display("FAIL midreset_latency: got %0d expected %0d", lat, ST); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL midreset_timeout: got no beat expected one"); end
    endtask

    // Three other geometries share a stimulus stream, each with its own scoreboard
    task automatic test_param_sweep();
        res_t q8[$], q32[$], q64[$];
        int   c8[$], c32[$], c64[$];
        res_t e, act;
        int   sent = 0, g8 = 0, g32 = 0, g64 = 0, lat;
        for (int t = 0; t < 5000 && (sent < 1000 || g8 < 1000 || g32 < 1000 || g64 < 1000); t++) begin
            @(negedge clk);
            sw_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            sw_a     = {$urandom, $urandom};
            sw_b     = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) sw_a = '1;
            if ($urandom_range(0, 7) == 0) sw_b = '0;
            sw_cin   = 1'($urandom_range(0, 1));
            sw_sub   = 1'($urandom_range(0, 1));
            #1;
            if (w8_if.out_valid) begin
                act = '{s: 64'(w8_if.s), c: w8_if.c_out, o: w8_if.ovf, pg: w8_if.pg, gg: w8_if.gg};
                checks++;
                if (q8.size() == 0) begin errors++; $display("FAIL w8_spurious: got %h expected no beat", act); end
                else begin
                    e = q8.pop_front(); lat = cyc - c8.pop_front();
                    if (act !== e) begin errors++; $display("FAIL w8_result: got %h expected %h", act, e); end
                    checks++; if (lat != 1) begin errors++; $display("FAIL w8_latency: got %0d expected 1", lat); end
                end
                g8++;
            end
            if (w32_if.out_valid) begin
                act = '{s: 64'(w32_if.s), c: w32_if.c_out, o: w32_if.ovf, pg: w32_if.pg, gg: w32_if.gg};
                checks++;
                if (q32.size() == 0) begin errors++; $display("FAIL w32_spurious: got %h expected no beat", act); end
                else begin
                    e = q32.pop_front(); lat = cyc - c32.pop_front();
                    if (act !== e) begin errors++; $display("FAIL w32_result: got %h expected %h", act, e); end
                    checks++; if (lat != 2) begin errors++; $display("FAIL w32_latency: got %0d expected 2", lat); end
                end
                g32++;
            end
            if (w64_if.out_valid) begin
                act = '{s: w64_if.s, c: w64_if.c_out, o: w64_if.ovf, pg: w64_if.pg, gg: w64_if.gg};
                checks++;
                if (q64.size() == 0) begin errors++; $display("FAIL w64_spurious: got %h expected no beat", act); end
                else begin
                    e = q64.pop_front(); lat = cyc - c64.pop_front();
                    if (act !== e) begin errors++; $display("FAIL w64_result: got %h expected %h", act, e); end
                    checks++; if (lat != 4) begin errors++; $display("FAIL w64_latency: got %0d expected 4", lat); end
                end
                g64++;
            end
            if (sw_valid) begin
                if (w8_if.in_ready)  begin q8.push_back(model(8, sw_a, sw_b, sw_cin, sw_sub));   c8.push_back(cyc);  end
                if (w32_if.in_ready) begin q32.push_back(model(32, sw_a, sw_b, sw_cin, sw_sub)); c32.push_back(cyc); end
                if (w64_if.in_ready) begin q64.push_back(model(64, sw_a, sw_b, sw_cin, sw_sub)); c64.push_back(cyc); end
                sent++;
            end
        end
        sw_valid = 1'b0;
        checks++;
        if (g8 != 1000 || g32 != 1000 || g64 != 1000) begin
            errors++; $display("FAIL sweep_count: got %0d/%0d/%0d expected 1000 each", g8, g32, g64);
        end
    endtask

    initial begin
        test_reset();
        test_carry_sub();
        test_backpressure();
        test_reset_midstream();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
